// File: rtl/div_counter_pkg.sv
// Shared types and constants for the picture division-step counter.
package div_counter_pkg;

  localparam int CNT_W        = 5;
  localparam int TERM_CNT_DEF = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RENEW = 2'd3
  } state_e;

endpackage

// File: rtl/div_counter.sv
// Division-step counter: counts TERM_CNT+1 cycles per picture, then strobes
// sort_reg_en and renew_index. Define DIV_COUNTER_CNT_OUT_EN to expose cnt_o.
module div_counter
  import div_counter_pkg::*;
#(
  parameter int TERM_CNT = TERM_CNT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             one_picture,
  output logic             sort_reg_en,
  output logic             renew_index,
`ifdef DIV_COUNTER_CNT_OUT_EN
  output logic             busy,
  output logic [CNT_W-1:0] cnt_o
`else
  output logic             busy
`endif
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TERM_CNT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sort_q, renew_q, busy_q;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (one_picture) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        if (one_picture) begin
          cnt_d = '0;
        end else if (cnt_q == TERM) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_RENEW;
      end
      ST_RENEW: begin
        // A new picture arriving here chains straight into the next count.
        state_d = one_picture ? ST_COUNT : ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are flopped from the next state, so they line up with the
  // state register and never see one_picture combinationally.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sort_q  <= 1'b0;
      renew_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sort_q  <= (state_d == ST_LOAD);
      renew_q <= (state_d == ST_RENEW);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign sort_reg_en = sort_q;
  assign renew_index = renew_q;
  assign busy        = busy_q;

`ifdef DIV_COUNTER_CNT_OUT_EN
  assign cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_div_counter.sv
// Self-checking bench for div_counter: scenario table on TERM_CNT=21,
// a short TERM_CNT=5 sequence, and random stimulus against a cycle-age model.
module tb_div_counter;
  import div_counter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic one_picture = 1'b0;
  logic sort21, renew21, busy21;
  logic sort5, renew5, busy5;
`ifdef DIV_COUNTER_CNT_OUT_EN
  logic [CNT_W-1:0] cnt21, cnt5;
`endif

  int errors = 0;
  int checks = 0;
  int k21 = -1;
  int k5  = -1;

  always #5 clk = ~clk;

  div_counter #(.TERM_CNT(21)) dut (
    .clk        (clk),
    .reset      (reset),
    .one_picture(one_picture),
    .sort_reg_en(sort21),
    .renew_index(renew21),
`ifdef DIV_COUNTER_CNT_OUT_EN
    .busy       (busy21),
    .cnt_o      (cnt21)
`else
    .busy       (busy21)
`endif
  );

  div_counter #(.TERM_CNT(5)) dut5 (
    .clk        (clk),
    .reset      (reset),
    .one_picture(one_picture),
    .sort_reg_en(sort5),
    .renew_index(renew5),
`ifdef DIV_COUNTER_CNT_OUT_EN
    .busy       (busy5),
    .cnt_o      (cnt5)
`else
    .busy       (busy5)
`endif
  );

  // Model state: edges elapsed since the accepted start, or -1 when idle.
  // Ages 0..t are counting, t+1 is the load cycle, t+2 the renew cycle.
  function automatic int model_next(int k, int t, logic rst, logic op);
    if (rst) return -1;
    if (k < 0) return op ? 0 : -1;
    if (k <= t) return op ? 0 : k + 1;
    if (k == t + 1) return t + 2;
    return op ? 0 : -1;
  endfunction

  function automatic logic [2:0] model_out(int k, int t);
    return {k >= 0, k == t + 1, k == t + 2};
  endfunction

  function automatic int model_cnt(int k, int t);
    return (k >= 0 && k <= t) ? k : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic op);
    reset       = r;
    one_picture = op;
    @(posedge clk);
    #1;
    k21 = model_next(k21, 21, r, op);
    k5  = model_next(k5, 5, r, op);
  endtask

  typedef struct {
    string name;
    int    op2_at;     // edge (after start edge 0) with a second one_picture pulse
    int    rst_at;     // edge with reset asserted
    int    exp_sort;   // cycle of first sort_reg_en, -1 for none
    int    exp_renew;  // cycle of first renew_index, -1 for none
    int    exp_busy;   // number of busy cycles in the window
    int    exp_nsort;  // total sort_reg_en strobes
  } scen_t;

  scen_t scens[5];

  task automatic run_scen(input scen_t s);
    int first_sort, first_renew, nbusy, nsort, noverlap;
    first_sort = -1; first_renew = -1; nbusy = 0; nsort = 0; noverlap = 0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check({s.name, " reset busy"}, busy21, 0);
    check({s.name, " reset strobes"}, {sort21, renew21}, 0);
    tick(1'b0, 1'b1);
    for (int n = 0; n < 60; n++) begin
      if (busy21) nbusy++;
      if (sort21) begin
        nsort++;
        if (first_sort < 0) first_sort = n;
      end
      if (renew21 && first_renew < 0) first_renew = n;
      if (sort21 && renew21) noverlap++;
      tick(n + 1 == s.rst_at, n + 1 == s.op2_at);
    end
    check({s.name, " sort cycle"}, first_sort, s.exp_sort);
    check({s.name, " renew cycle"}, first_renew, s.exp_renew);
    check({s.name, " busy cycles"}, nbusy, s.exp_busy);
    check({s.name, " sort count"}, nsort, s.exp_nsort);
    check({s.name, " strobe overlap"}, noverlap, 0);
  endtask

  initial begin
    int exp_cnt5[8];
    logic op, rst;

    scens[0] = '{"single",      -1, -1, 22, 23, 24, 1};
    scens[1] = '{"restart",     11, -1, 33, 34, 35, 1};
    scens[2] = '{"op_in_load",  23, -1, 22, 23, 24, 1};
    scens[3] = '{"op_in_renew", 24, -1, 22, 23, 48, 2};
    scens[4] = '{"reset_mid",   -1, 16, -1, -1, 16, 0};

    for (int i = 0; i < 5; i++) run_scen(scens[i]);

    // TERM_CNT=5 instance: count steps and strobe timing.
    exp_cnt5 = '{0, 1, 2, 3, 4, 5, 0, 0};
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("t5 sort c%0d", n), sort5, (n == 6) ? 1 : 0);
      check($sformatf("t5 renew c%0d", n), renew5, (n == 7) ? 1 : 0);
`ifdef DIV_COUNTER_CNT_OUT_EN
      check($sformatf("t5 cnt c%0d", n), cnt5, exp_cnt5[n]);
`endif
      tick(1'b0, 1'b0);
    end

    // Random pulses and occasional resets against the model.
    tick(1'b1, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      op  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 63) == 0);
      if (n % 500 < 100) op = ($urandom_range(0, 40) == 0);
      tick(rst, op);
      check("rand t21 outs", {busy21, sort21, renew21}, model_out(k21, 21));
      check("rand t5 outs", {busy5, sort5, renew5}, model_out(k5, 5));
`ifdef DIV_COUNTER_CNT_OUT_EN
      check("rand t21 cnt", cnt21, model_cnt(k21, 21));
      check("rand t5 cnt", cnt5, model_cnt(k5, 5));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
